block_transfer_sequencer: RTL and testbench
===========================================

// Module: block_transfer_sequencer
// PURPOSE
//  Clocked issuer for load/store-multiple instructions; drives the transfer side of the register-list protocol.
//  Latches a 16-bit register list and base address, then presents one (register, memory address) pair per set bit.
//  Order is lowest register first, with a valid/ready handshake to the memory interface.
//  Computes the base-register writeback value and signals completion to the control unit.
// PARAMETERS
//  ADDR_W  32  memory address / base register width
//  LIST_W  16  register-list width; register index width is $clog2(LIST_W) = 4
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       launch request; sampled only in IDLE
//  reg_list    in   LIST_W  bit i set = transfer register i
//  base_addr   in   ADDR_W  contents of base register Rn
//  p_bit       in   1       1 = pre-index (before), 0 = post-index (after)
//  u_bit       in   1       1 = increment (up), 0 = decrement (down)
//  busy        out  1       high from the start acceptance until done
//  xfer_valid  out  1       current reg_address/mem_addr pair is valid
//  xfer_ready  in   1       memory operation complete; accepts the current pair
//  reg_address out  4       register index of the current transfer
//  mem_addr    out  ADDR_W  word address of the current transfer
//  wb_addr     out  ADDR_W  base-register writeback value
//  done        out  1       one-cycle pulse when the sequence finishes
// BEHAVIOUR
//  Reset: all outputs are 0; FSM is in IDLE; latched list, base and bits are cleared. Reset mid-sequence aborts immediately, with no further transfers.
//  FSM states: IDLE -> SETUP -> XFER -> DONE -> IDLE.
//  IDLE:  when start=1, latch reg_list, base_addr, p_bit and u_bit, and set busy=1. start is ignored in every other state.
//  SETUP: one cycle. n = popcount(list), computed as an (ADDR_W)-bit value.
//   Start address by mode: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n.
//   wb_addr = u ? base+4n : base-4n.
//   If n==0, go to DONE with no transfers and wb_addr = base. Otherwise go to XFER.
//  XFER:  xfer_valid=1. reg_address = index of the lowest remaining set bit. mem_addr = running address.
//   All three outputs stay stable while xfer_ready=0.
//   On xfer_valid&&xfer_ready, clear that bit and add 4 to the running address (ascending for every mode).
//   If no bits remain, go to DONE; otherwise present the next pair in the following cycle.
//   Accepted transfers are back-to-back: one per cycle when xfer_ready is held at 1.
//  DONE:  done=1 for exactly one cycle; xfer_valid=0; busy falls in the same cycle. Next state is IDLE.
//   wb_addr holds its value until the next start is accepted.
//  Latency: start accepted at edge T; first xfer_valid at T+2; done at T+2+k, where k = cycles spent in XFER.
//  Arithmetic: all address math is modulo 2^ADDR_W; wrap-around is silent; the low 2 bits pass through unaltered.
//  A change in reg_list or base_addr after acceptance has no effect on the running sequence.
// STRUCTURE
//  Shared package (cu_pkg): FSM state encoding (2-bit: IDLE/SETUP/XFER/DONE) and the WORD_BYTES=4 constant.
//  Sub-module lsb_priority_encoder: combinational; input LIST_W bits, outputs index[3:0] and any.
//   It finds the lowest set bit of the remaining-list register.
//  Popcount, address adders and the FSM stay in this module.
// TESTING
//  1. list=16'h8001, base=0x100, IA, ready=1 -> (r0,0x100), (r15,0x104); done at T+4; wb=0x108.
//  2. list=16'h00F0, base=0x200, DB -> (r4,0x1F0), (r5,0x1F4), (r6,0x1F8), (r7,0x1FC); wb=0x1F0.
//  3. list=16'h0006, base=0x40, IB, ready low 3 cycles per beat -> (r1,0x44) then (r2,0x48).
//     Outputs must stay stable while stalled; wb=0x48.
//  4. list=0, base=0x80 -> no xfer_valid; done at T+2; wb=0x80; a start while busy is ignored.
//  5. list=16'hFFFF, base=0xFFFFFFF0, DA -> first (r0,0xFFFFFFB4), last (r15,0xFFFFFFF0).
//     Wraps cleanly; wb=0xFFFFFFB0.
//  6. reset asserted during the 2nd beat of case 2 -> outputs 0 at once; a new start then runs normally.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the block transfer sequencer: FSM state encoding and
// the byte size of one transferred word.
package cu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 32'd4;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit finder used to pick the next register of a
// load/store-multiple list.
module lsb_priority_encoder #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = $clog2(LIST_W)
) (
  input  logic [LIST_W-1:0] list_i,
  output logic [IDX_W-1:0]  index_o,
  output logic              any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    any_o   = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_i[i]) begin
        index_o = IDX_W'(i);
        any_o   = 1'b1;
      end else begin
        index_o = index_o;
      end
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// Load/store-multiple issuer: walks a latched register list lowest-first and
// presents one (register, address) pair per set bit over valid/ready.
module block_transfer_sequencer
  import cu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 16,
  parameter int IDX_W  = $clog2(LIST_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              p_bit,
  input  logic              u_bit,
  output logic              busy,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [IDX_W-1:0]  reg_address,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  function automatic logic [ADDR_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [ADDR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LIST_W; i++) begin
      cnt = cnt + ADDR_W'(v[i]);
    end
    return cnt;
  endfunction

  state_e            state_q, state_d;
  logic [LIST_W-1:0] list_q, list_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              p_q, p_d;
  logic              u_q, u_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              accept_s;
  logic [LIST_W-1:0] list_clr_s;
  logic [LIST_W-1:0] enc_in_s;
  logic [IDX_W-1:0]  enc_idx_s;
  logic              enc_any_s;
  logic [ADDR_W-1:0] four_n_s;
  logic [ADDR_W-1:0] start_addr_s;

  // The encoder looks at the list as it will be after this cycle, so the
  // registered reg_address already points at the next remaining register.
  assign accept_s   = (state_q == ST_XFER) && valid_q && xfer_ready;
  assign list_clr_s = list_q & ~(LIST_W'(1) << idx_q);
  assign enc_in_s   = accept_s ? list_clr_s : list_q;

  lsb_priority_encoder #(
    .LIST_W (LIST_W),
    .IDX_W  (IDX_W)
  ) u_enc (
    .list_i  (enc_in_s),
    .index_o (enc_idx_s),
    .any_o   (enc_any_s)
  );

  // Block size in bytes and the lowest address touched for each P/U mode.
  always_comb begin
    four_n_s = popcount(list_q) * STEP;
    case ({p_q, u_q})
      2'b01:   start_addr_s = base_q;
      2'b11:   start_addr_s = base_q + STEP;
      2'b00:   start_addr_s = base_q - four_n_s + STEP;
      2'b10:   start_addr_s = base_q - four_n_s;
      default: start_addr_s = base_q;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    base_d  = base_q;
    p_d     = p_q;
    u_d     = u_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wb_d    = wb_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          list_d  = reg_list;
          base_d  = base_addr;
          p_d     = p_bit;
          u_d     = u_bit;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SETUP: begin
        wb_d = u_q ? (base_q + four_n_s) : (base_q - four_n_s);
        if (enc_any_s) begin
          valid_d = 1'b1;
          addr_d  = start_addr_s;
          idx_d   = enc_idx_s;
          state_d = ST_XFER;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_XFER: begin
        if (accept_s) begin
          list_d = list_clr_s;
          addr_d = addr_q + STEP;
          if (enc_any_s) begin
            idx_d = enc_idx_s;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      base_q  <= '0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      wb_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      base_q  <= base_d;
      p_q     <= p_d;
      u_q     <= u_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wb_q    <= wb_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign xfer_valid  = valid_q;
  assign reg_address = idx_q;
  assign mem_addr    = addr_q;
  assign wb_addr     = wb_q;
  assign done        = done_q;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench: directed and random load/store-multiple sequences checked
// against an arithmetic model of the register-list transfer rules.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        p_bit;
  logic        u_bit;
  logic        busy;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [3:0]  reg_address;
  logic [31:0] mem_addr;
  logic [31:0] wb_addr;
  logic        done;

  int passes = 0;
  int total  = 0;

  block_transfer_sequencer #(.ADDR_W(32), .LIST_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .reg_list    (reg_list),
    .base_addr   (base_addr),
    .p_bit       (p_bit),
    .u_bit       (u_bit),
    .busy        (busy),
    .xfer_valid  (xfer_valid),
    .xfer_ready  (xfer_ready),
    .reg_address (reg_address),
    .mem_addr    (mem_addr),
    .wb_addr     (wb_addr),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":busy"},  64'(busy), 64'd0);
    check({tag, ":valid"}, 64'(xfer_valid), 64'd0);
    check({tag, ":done"},  64'(done), 64'd0);
    check({tag, ":reg"},   64'(reg_address), 64'd0);
    check({tag, ":mem"},   64'(mem_addr), 64'd0);
    check({tag, ":wb"},    64'(wb_addr), 64'd0);
  endtask

  // mode: 0 ready always high, 1 ready low 3 cycles per beat, 2 random ready.
  // abort_beat >= 0 pulses reset while that beat is being presented.
  task automatic run_seq(input logic [15:0] list, input logic [31:0] base,
                         input logic p, input logic u, input int mode,
                         input int abort_beat, input string name);
    logic [3:0]  exp_reg[16];
    logic [31:0] exp_addr[16];
    logic [31:0] lo, exp_wb;
    int n, beat, vcount, c, stall, bi;
    bit finished;
    logic rdy;

    // Model: registers ascending map onto consecutive ascending words.
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    if (u) lo = base + (p ? 32'd4 : 32'd0);
    else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    exp_wb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    bi = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_reg[bi]  = 4'(i);
        exp_addr[bi] = lo + 32'(4 * bi);
        bi++;
      end
    end

    @(negedge clk);
    reg_list = list; base_addr = base; p_bit = p; u_bit = u;
    start = 1'b1; xfer_ready = 1'b0;
    @(negedge clk);
    check({name, ":busy_after_start"}, 64'(busy), 64'd1);
    check({name, ":valid_in_setup"}, 64'(xfer_valid), 64'd0);
    // Scramble inputs and hold start while busy: both must be ignored.
    reg_list = 16'($urandom); base_addr = $urandom; p_bit = ~p; u_bit = ~u;
    @(negedge clk);
    start = 1'b0;
    c = 1; beat = 0; vcount = 0; stall = 0; finished = 1'b0;
    while (!finished && c < 400) begin
      if (abort_beat >= 0 && beat == abort_beat && xfer_valid) begin
        reset = 1'b1;
        #1;
        check_all_zero({name, ":abort"});
        @(negedge clk);
        check({name, ":abort_hold_valid"}, 64'(xfer_valid), 64'd0);
        reset = 1'b0;
        xfer_ready = 1'b0;
        finished = 1'b1;
      end else if (done) begin
        check({name, ":done_latency"}, 64'(c), 64'(1 + vcount));
        check({name, ":beats"}, 64'(beat), 64'(n));
        check({name, ":wb"}, 64'(wb_addr), 64'(exp_wb));
        check({name, ":valid_at_done"}, 64'(xfer_valid), 64'd0);
        check({name, ":busy_at_done"}, 64'(busy), 64'd0);
        finished = 1'b1;
      end else begin
        check({name, ":busy"}, 64'(busy), 64'd1);
        check({name, ":valid"}, 64'(xfer_valid), 64'd1);
        bi = (beat < 16) ? beat : 0;
        check({name, ":beat_in_range"}, 64'(beat < n), 64'd1);
        check({name, ":reg"}, 64'(reg_address), 64'(exp_reg[bi]));
        check({name, ":addr"}, 64'(mem_addr), 64'(exp_addr[bi]));
        vcount++;
        case (mode)
          0: rdy = 1'b1;
          1: begin
            if (stall < 3) begin rdy = 1'b0; stall++; end
            else begin rdy = 1'b1; stall = 0; end
          end
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        xfer_ready = rdy;
        if (rdy) beat++;
        @(negedge clk);
        c++;
      end
    end
    check({name, ":finished"}, 64'(finished), 64'd1);
    if (abort_beat < 0) begin
      xfer_ready = 1'b0;
      @(negedge clk);
      check({name, ":done_one_cycle"}, 64'(done), 64'd0);
      check({name, ":wb_hold"}, 64'(wb_addr), 64'(exp_wb));
      check({name, ":idle_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reg_list = 16'd0; base_addr = 32'd0;
    p_bit = 1'b0; u_bit = 1'b0; xfer_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    run_seq(16'h8001, 32'h0000_0100, 1'b0, 1'b1, 0, -1, "ia");
    run_seq(16'h00F0, 32'h0000_0200, 1'b1, 1'b0, 0, -1, "db");
    run_seq(16'h0006, 32'h0000_0040, 1'b1, 1'b1, 1, -1, "ib_stall");
    run_seq(16'h0000, 32'h0000_0080, 1'b0, 1'b1, 0, -1, "empty");
    run_seq(16'hFFFF, 32'hFFFF_FFF0, 1'b0, 1'b0, 0, -1, "da_wrap");
    run_seq(16'h00F0, 32'h0000_0200, 1'b1, 1'b0, 0, 1, "db_abort");
    run_seq(16'h8001, 32'h0000_0100, 1'b0, 1'b1, 0, -1, "after_abort");

    for (int i = 0; i < 10; i++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if (i % 3 == 0) l = 16'd1 << $urandom_range(0, 15);
      run_seq(l, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2, -1, "random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
